// File: rtl/iob_fifo_wr_arbiter.sv
// iob_fifo_wr_arbiter: round-robin arbiter sharing the write port of one FIFO
// between N requesters, granting bursts of up to BURST_LEN words each.
// Optional feature: define IOB_FIFO_WR_ARBITER_RESERVE_EN so that a grant is only
// issued when the FIFO already has room for a whole burst.
module iob_fifo_wr_arbiter #(
   parameter int N         = 2,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int BURST_LEN = 4
) (
   input  logic                clk_i,
   input  logic                arst_i,
   input  logic                cke_i,
   input  logic                rst_i,
   input  logic [N-1:0]        req_i,
   input  logic [N*DATA_W-1:0] data_i,
   output logic [N-1:0]        ack_o,
   output logic [N-1:0]        grant_o,
   output logic                w_en_o,
   output logic [DATA_W-1:0]   w_data_o,
   input  logic                w_full_i,
   input  logic [ADDR_W-1:0]   w_level_i
);

   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);
   localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W + 1)'(1) << ADDR_W;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] OWN  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [N-1:0]      grant_q, grant_d;

   logic              req_own;
   logic              accept;
   logic [DATA_W-1:0] owner_data;
   logic [ADDR_W:0]   free_w;
   logic [N-1:0]      eligible;
   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic [IDX_W-1:0]  ptr_next;

   // Free space in the FIFO; the level wraps to 0 when full, hence the full override.
   assign free_w = w_full_i ? '0 : (DEPTH - {1'b0, w_level_i});

`ifdef IOB_FIFO_WR_ARBITER_RESERVE_EN
   // Only requesters that can complete a whole burst without stalling are eligible.
   assign eligible = (free_w >= (ADDR_W + 1)'(BURST_LEN)) ? req_i : '0;
`else
   logic unused_free;
   assign unused_free = ^free_w;
   assign eligible    = req_i;
`endif

   // grant_q is one-hot on the owner while in OWN, so it doubles as the owner mask.
   assign req_own  = |(req_i & grant_q);
   assign accept   = (state_q == OWN) & req_own & ~w_full_i & cke_i;
   assign ptr_next = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

   assign w_en_o   = accept;
   assign ack_o    = accept ? grant_q : '0;
   assign grant_o  = grant_q;
   assign w_data_o = (state_q == OWN) ? owner_data : '0;

   // Select the owner's data slice.
   always_comb begin
      owner_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (IDX_W'(i) == owner_q) owner_data = data_i[i*DATA_W +: DATA_W];
      end
   end

   // Round-robin scan: first eligible requester starting at ptr_q and wrapping.
   always_comb begin
      logic [IDX_W-1:0] cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = ptr_q;
      for (int unsigned k = 0; k < N; k++) begin
         if (!pick_found && eligible[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
         cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
      end
   end

   // Next-state logic: grant in IDLE, count beats / release / stall in OWN.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      beat_d  = beat_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d           = OWN;
               owner_d           = pick_idx;
               beat_d            = '0;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
            end
         end
         OWN: begin
            if (!req_own || (accept && (beat_q == LAST_BEAT))) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = ptr_next;
            end else if (accept) begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State registers: async reset, then clock-enabled sync reset or update.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         beat_q  <= '0;
         grant_q <= '0;
      end else if (cke_i) begin
         if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            grant_q <= '0;
         end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            grant_q <= grant_d;
         end
      end
   end

endmodule

// File: tb/tb_iob_fifo_wr_arbiter.sv
// Testbench for iob_fifo_wr_arbiter: vector table, corner-case sequences and a
// randomized run checked against a behavioural model with a FIFO occupancy model.
module tb_iob_fifo_wr_arbiter;

   localparam int N         = 2;
   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 4;
   localparam int BURST_LEN = 4;
   localparam int DEPTH     = 16;

   logic                clk_i = 1'b0;
   logic                arst_i;
   logic                cke_i;
   logic                rst_i;
   logic [N-1:0]        req_i;
   logic [N*DATA_W-1:0] data_i;
   logic [N-1:0]        ack_o;
   logic [N-1:0]        grant_o;
   logic                w_en_o;
   logic [DATA_W-1:0]   w_data_o;
   logic                w_full_i;
   logic [ADDR_W-1:0]   w_level_i;

   iob_fifo_wr_arbiter #(
      .N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)
   ) dut (
      .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i),
      .req_i(req_i), .data_i(data_i), .ack_o(ack_o), .grant_o(grant_o),
      .w_en_o(w_en_o), .w_data_o(w_data_o), .w_full_i(w_full_i), .w_level_i(w_level_i)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   // bench stimulus state
   logic [N-1:0]      b_req;
   logic              b_cke;
   logic              b_rst;
   logic              b_drain;
   logic [DATA_W-1:0] b_word [N];

   // reference model: owner index (-1 when nobody holds the port)
   int m_owner;
   int m_ptr;
   int m_done;
   int f_count;
   int dut_words;
   int stall_cycles;

   typedef struct {
      logic [1:0] req;
      logic [3:0] level;
      logic [1:0] grant;
      logic       wen;
      logic [1:0] ack;
      logic [7:0] wdata;
   } vec_t;

   vec_t vec [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit has(input logic [N-1:0] v, input int i);
      return ((int'(v) >> i) & 1) == 1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_done  = 0;
   endtask

   task automatic cycle(input string tag);
      logic [N-1:0]      e_grant;
      logic [N-1:0]      e_ack;
      logic [DATA_W-1:0] e_wdata;
      bit                acc;
      bit                full;
      bit                room;
      int                idx;
`ifdef IOB_FIFO_WR_ARBITER_RESERVE_EN
      int                fr;
`endif
      @(negedge clk_i);
      full      = (f_count == DEPTH);
      req_i     = b_req;
      cke_i     = b_cke;
      rst_i     = b_rst;
      w_full_i  = full;
      w_level_i = ADDR_W'(f_count % DEPTH);
      for (int i = 0; i < N; i++) data_i[i*DATA_W +: DATA_W] = b_word[i];
      #1;
      acc     = (m_owner >= 0) && has(b_req, m_owner) && !full && b_cke;
      e_grant = (m_owner >= 0) ? N'(32'd1 << m_owner) : '0;
      e_ack   = acc ? e_grant : '0;
      e_wdata = (m_owner >= 0) ? b_word[m_owner] : '0;
      check({tag, ".grant"}, 32'(grant_o), 32'(e_grant));
      check({tag, ".w_en"}, 32'(w_en_o), 32'(acc));
      check({tag, ".ack"}, 32'(ack_o), 32'(e_ack));
      check({tag, ".w_data"}, 32'(w_data_o), 32'(e_wdata));
      if (w_en_o === 1'b1) dut_words++;
      if (grant_o !== '0 && full) stall_cycles++;
      if (b_cke) begin
         if (b_rst) begin
            model_reset();
         end else if (m_owner < 0) begin
`ifdef IOB_FIFO_WR_ARBITER_RESERVE_EN
            fr   = full ? 0 : DEPTH - (f_count % DEPTH);
            room = (fr >= BURST_LEN);
`else
            room = 1'b1;
`endif
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (m_owner < 0 && room && has(b_req, idx)) begin
                  m_owner = idx;
                  m_done  = 0;
               end
            end
         end else if (!has(b_req, m_owner)) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end else if (acc) begin
            m_done++;
            if (m_done == BURST_LEN) begin
               m_ptr   = (m_owner + 1) % N;
               m_owner = -1;
            end
         end
      end
      f_count = f_count + (acc ? 1 : 0) - ((b_drain && f_count > 0) ? 1 : 0);
   endtask

   // Async reset asserted between edges: outputs must clear before the next edge.
   task automatic pulse_arst(input string tag);
      @(negedge clk_i);
      arst_i = 1'b1;
      #1;
      check({tag, ".arst_grant"}, 32'(grant_o), 32'd0);
      check({tag, ".arst_w_en"}, 32'(w_en_o), 32'd0);
      check({tag, ".arst_ack"}, 32'(ack_o), 32'd0);
      @(posedge clk_i);
      #1;
      arst_i = 1'b0;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec[0]  = '{2'b11, 4'd0, 2'b00, 1'b0, 2'b00, 8'h00};
      vec[1]  = '{2'b11, 4'd0, 2'b01, 1'b1, 2'b01, 8'hA0};
      vec[2]  = '{2'b11, 4'd1, 2'b01, 1'b1, 2'b01, 8'hA0};
      vec[3]  = '{2'b11, 4'd2, 2'b01, 1'b1, 2'b01, 8'hA0};
      vec[4]  = '{2'b11, 4'd3, 2'b01, 1'b1, 2'b01, 8'hA0};
      vec[5]  = '{2'b11, 4'd4, 2'b00, 1'b0, 2'b00, 8'h00};
      vec[6]  = '{2'b11, 4'd4, 2'b10, 1'b1, 2'b10, 8'hB1};
      vec[7]  = '{2'b11, 4'd5, 2'b10, 1'b1, 2'b10, 8'hB1};
      vec[8]  = '{2'b11, 4'd6, 2'b10, 1'b1, 2'b10, 8'hB1};
      vec[9]  = '{2'b11, 4'd7, 2'b10, 1'b1, 2'b10, 8'hB1};
      vec[10] = '{2'b11, 4'd8, 2'b00, 1'b0, 2'b00, 8'h00};
      vec[11] = '{2'b11, 4'd8, 2'b01, 1'b1, 2'b01, 8'hA0};

      arst_i    = 1'b1;
      cke_i     = 1'b1;
      rst_i     = 1'b0;
      req_i     = 2'b11;
      data_i    = 16'hB1A0;
      w_full_i  = 1'b0;
      w_level_i = '0;
      b_req     = '0;
      b_cke     = 1'b1;
      b_rst     = 1'b0;
      b_drain   = 1'b0;
      b_word[0] = 8'hA0;
      b_word[1] = 8'hB1;
      model_reset();
      f_count      = 0;
      dut_words    = 0;
      stall_cycles = 0;

      // reset state while arst is held and requests are pending
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("reset.grant", 32'(grant_o), 32'd0);
      check("reset.w_en", 32'(w_en_o), 32'd0);
      check("reset.ack", 32'(ack_o), 32'd0);
      check("reset.w_data", 32'(w_data_o), 32'd0);
      req_i  = '0;
      arst_i = 1'b0;

      // continuous 2'b11 on an empty FIFO: 0,0,0,0,idle,1,1,1,1,idle,0...
      for (int r = 0; r < 12; r++) begin
         @(negedge clk_i);
         req_i     = vec[r].req;
         w_level_i = vec[r].level;
         w_full_i  = 1'b0;
         cke_i     = 1'b1;
         rst_i     = 1'b0;
         data_i    = 16'hB1A0;
         #1;
         check($sformatf("vec%0d.grant", r), 32'(grant_o), 32'(vec[r].grant));
         check($sformatf("vec%0d.w_en", r), 32'(w_en_o), 32'(vec[r].wen));
         check($sformatf("vec%0d.ack", r), 32'(ack_o), 32'(vec[r].ack));
         check($sformatf("vec%0d.w_data", r), 32'(w_data_o), 32'(vec[r].wdata));
      end
      pulse_arst("vec_end");

      // owner 0 drops its request after two words; requester 1 takes over
      f_count = 0;
      b_req   = 2'b11;
      repeat (3) cycle("rel");
      b_req = 2'b10;
      repeat (3) cycle("rel");
      check("rel.grant_owner1", 32'(grant_o), 32'(2'b10));
      b_req = 2'b00;
      repeat (6) cycle("rel_tail");
      pulse_arst("rel_end");

      // FIFO at 15/16: stall on full (or wait for room when reserving), then drain
      f_count      = 15;
      b_req        = 2'b01;
      dut_words    = 0;
      stall_cycles = 0;
      repeat (4) cycle("full");
      b_drain = 1'b1;
      for (int c = 0; c < 20; c++) begin
         cycle("full_drain");
         if (dut_words >= 4) b_req = 2'b00;
      end
      b_drain = 1'b0;
      check("full.words", 32'(dut_words), 32'd4);
`ifdef IOB_FIFO_WR_ARBITER_RESERVE_EN
      check("full.stalls", 32'(stall_cycles), 32'd0);
`else
      check("full.stalls", 32'(stall_cycles), 32'd3);
`endif
      pulse_arst("full_end");

      // async reset mid-burst: partial burst not replayed, arbitration from ptr 0
      f_count = 0;
      b_req   = 2'b01;
      repeat (5) cycle("arst_a");
      b_req = 2'b11;
      cycle("arst_b");
      dut_words = 0;
      repeat (2) cycle("arst_b");
      pulse_arst("arst_mid");
      check("arst.partial_words", 32'(dut_words), 32'd2);
      repeat (2) cycle("arst_c");
      check("arst.restart_owner0", 32'(grant_o), 32'(2'b01));
      pulse_arst("arst_end");

      // clock enable low for three cycles mid-burst
      f_count   = 0;
      b_req     = 2'b01;
      dut_words = 0;
      repeat (3) cycle("cke_a");
      b_cke = 1'b0;
      repeat (3) cycle("cke_off");
      b_cke = 1'b1;
      for (int c = 0; c < 6; c++) begin
         cycle("cke_b");
         if (dut_words >= 4) b_req = 2'b00;
      end
      check("cke.words", 32'(dut_words), 32'd4);
      pulse_arst("cke_end");

      // randomized traffic against the model
      f_count = 0;
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0, 3) == 0) b_req = N'($urandom_range(0, 3));
         b_cke   = ($urandom_range(0, 7) != 0);
         b_rst   = ($urandom_range(0, 59) == 0);
         b_drain = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < N; i++) b_word[i] = DATA_W'($urandom);
         cycle("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iob_fifo_wr_arbiter.md
# iob_fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one FIFO between N requesters in a single clock domain. It grants the port to one requester at a time for a bounded burst of up to BURST_LEN words. It forwards that requester's words to the FIFO write port, throttled by the FIFO full flag, and acknowledges each accepted word back to the owner. It sits between the producer blocks and the write port of an iob FIFO (sync or async), driven by that FIFO's write-domain full and level outputs.

## Interface

- N, 2: number of requesters (≥2).
- DATA_W, 8: FIFO write data width.
- ADDR_W, 4: FIFO level width; FIFO depth is 2^ADDR_W words.
- BURST_LEN, 4: maximum words accepted per grant (1..2^ADDR_W).

Ports:

- clk_i  in  1  clock; all state updates on its rising edge.
- arst_i  in  1  asynchronous reset, active-high.
- cke_i  in  1  clock enable; when low, all state holds and w_en_o/ack_o are 0.
- rst_i  in  1  synchronous reset, active-high, effective only when cke_i=1; same values as arst_i.
- req_i  in  N  requester i holds a valid word.
- data_i  in  N*DATA_W  requester i word at bits [i*DATA_W +: DATA_W].
- ack_o  out  N  requester i word consumed this cycle; one-hot or zero.
- grant_o  out  N  registered one-hot current owner; zero when idle.
- w_en_o  out  1  FIFO write enable.
- w_data_o  out  DATA_W  FIFO write data.
- w_full_i  in  1  FIFO write-domain full flag.
- w_level_i  in  ADDR_W  FIFO write-domain level; wraps to 0 when full.

## Operation

- Registers:
  - state: IDLE or OWN.
  - owner: index, ceil(log2 N) bits.
  - ptr: round-robin start index.
  - beat_cnt: counts 0..BURST_LEN-1.
- Reset values: state=IDLE, owner=0, ptr=0, beat_cnt=0, grant_o=0. With these values w_en_o=0, ack_o=0 and w_data_o=0.
- IDLE:
  - Pick the first i with req_i[i]=1, scanning ptr, ptr+1, … mod N.
  - If an eligible i is found: owner←i, grant_o←1<<i, beat_cnt←0, state←OWN.
  - No transfer occurs in IDLE.
- OWN:
  - accept = req_i[owner] & ~w_full_i & cke_i.
  - w_en_o = accept; ack_o = accept<<owner; w_data_o = data_i slice of owner.
  - Combinational path from req_i/w_full_i to w_en_o/ack_o is allowed.
- OWN transitions, in priority order:
  - req_i[owner]=0: release. state←IDLE, grant_o←0, ptr←(owner+1) mod N; no write that cycle.
  - accept and beat_cnt=BURST_LEN-1: burst done. Same release updates as above.
  - accept otherwise: beat_cnt←beat_cnt+1.
  - w_full_i=1 with req held: stall; state, beat_cnt and grant_o hold.
- In IDLE, w_data_o=0.
- Requesters must hold req_i and data_i stable until ack_o; dropping req_i forfeits the grant.
- ptr advances only on release, so every requester is served within N grants.
- Free space: free = w_full_i ? 0 : 2^ADDR_W − w_level_i, computed in ADDR_W+1 bits unsigned.

## Timing

- Grant latency: req_i seen in IDLE → grant_o one cycle later → first ack_o/w_en_o in that same cycle if not full.
- Sustained throughput per burst: BURST_LEN words in BURST_LEN+1 cycles. Stall cycles on full are added on top.
- Simultaneous release and new request: re-arbitration happens in the following IDLE cycle. A requester is never regranted in the release cycle itself.
- N=2 wrap: ptr from 1 returns to 0.
- arst_i mid-burst: immediate IDLE. Words already acked stay in the FIFO; the partial burst is not replayed.
- cke_i=0 mid-burst: freeze; the burst resumes with the same beat_cnt.

## Configuration

- IOB_FIFO_WR_ARBITER_RESERVE_EN defined:
  - In IDLE, a requester is eligible only if free ≥ BURST_LEN; otherwise no grant and ptr holds.
  - A granted burst therefore never stalls on w_full_i unless another writer shares the FIFO.
- Undefined:
  - Grant is issued regardless of free space.
  - The owner stalls in OWN while w_full_i=1.

## Test plan

- N=2, BURST_LEN=4, req_i=2'b11 continuously, FIFO empty → writes in order 0,0,0,0,1,1,1,1,0…, one idle cycle between bursts, ack_o matches w_en_o.
- Owner 0 drops req_i after 2 words, req_i[1]=1 → owner 0 released, grant_o=2'b10 on the next cycle, ptr=1.
- FIFO at level 15 of 16, owner 0 with 4 words, macro undefined → 1 word written, stall while w_full_i=1, remaining 3 written after the FIFO drains, beat_cnt preserved.
- Same setup with IOB_FIFO_WR_ARBITER_RESERVE_EN: free=1<4 → grant_o stays 0. Once level≤12, grant is issued and 4 words are written without stall.
- arst_i pulsed mid-burst after 2 words → grant_o=0, w_en_o=0 immediately. After release, arbitration restarts from ptr=0 and exactly 2 words remain in the FIFO.
- cke_i low for 3 cycles mid-burst → no w_en_o, state frozen. Burst completes with a total of 4 words after cke_i returns high.
